// File: rtl/srl_hs_fifo.sv
// Shift-register FIFO with an ap_fifo-style handshake.
// Tracks occupancy, registers the full/empty/almost-full flags, and supports a synchronous flush.
// The data array has no reset, so synthesis can still map it onto SRL primitives.
module srl_hs_fifo #(
  parameter int unsigned DATA_WIDTH = 1,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned ADDR_WIDTH = 1,
  parameter int unsigned AF_MARGIN  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int unsigned         AfLevel  = DEPTH - AF_MARGIN;
  localparam logic [ADDR_WIDTH:0] DepthC   = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AfLevelC = AfLevel[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] CountOne = 1;
  localparam logic [ADDR_WIDTH-1:0] AddrOne = 1;

  logic [DATA_WIDTH-1:0] srl_q [DEPTH];
  logic [DATA_WIDTH-1:0] srl_d [DEPTH];

  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  empty_n_q, empty_n_d;
  logic                  full_n_q, full_n_d;
  logic                  af_q, af_d;

  logic                  wr_acc;
  logic                  rd_acc;
  logic [ADDR_WIDTH-1:0] rd_addr;

  // Handshake qualification: a write while full or a read while empty is dropped.
  always_comb begin
    wr_acc = if_write & if_write_ce & full_n_q;
    rd_acc = if_read & if_read_ce & empty_n_q;
  end

  // Shift new data in at entry 0. Older entries move toward higher indices.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      srl_d[i] = srl_q[i];
    end
    if (wr_acc) begin
      srl_d[0] = if_din;
      for (int i = 1; i < DEPTH; i++) begin
        srl_d[i] = srl_q[i-1];
      end
    end
  end

  // The storage has no reset, which keeps the array SRL-inferable.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      srl_q[i] <= srl_d[i];
    end
  end

  // Next occupancy. Flush overrides both accepted write and accepted read.
  always_comb begin
    count_d = count_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CountOne;
      2'b01:   count_d = count_q - CountOne;
      default: count_d = count_q;
    endcase
    if (flush) begin
      count_d = '0;
    end
  end

  // Flags are computed from the next count, so they change on the same edge as count.
  always_comb begin
    empty_n_d = (count_d != '0);
    full_n_d  = (count_d != DepthC);
    af_d      = (count_d >= AfLevelC);
  end

  // Occupancy and flag registers. Reset clears them asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q   <= '0;
      empty_n_q <= 1'b0;
      full_n_q  <= 1'b1;
      af_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      empty_n_q <= empty_n_d;
      full_n_q  <= full_n_d;
      af_q      <= af_d;
    end
  end

  // The head is the oldest entry, at count-1. The address is clamped to 0 when the FIFO is empty.
  always_comb begin
    rd_addr = '0;
    if (count_q != '0) begin
      rd_addr = count_q[ADDR_WIDTH-1:0] - AddrOne;
    end
  end

  // Drive the output ports from the registered state and the head entry.
  always_comb begin
    if_dout     = srl_q[rd_addr];
    if_empty_n  = empty_n_q;
    if_full_n   = full_n_q;
    almost_full = af_q;
    count       = count_q;
  end

  // Structural invariants of the occupancy state.
  a_count_bound : assert property (@(posedge clk) disable iff (reset) count_q <= DepthC);
  a_flags_sane  : assert property (@(posedge clk) disable iff (reset) full_n_q | empty_n_q);
  a_empty_match : assert property (@(posedge clk) disable iff (reset)
                                   empty_n_q == (count_q != '0));

endmodule

// File: tb/tb_srl_hs_fifo.sv
// Directed bench for srl_hs_fifo with DATA_WIDTH=8, DEPTH=4 and AF_MARGIN=1.
// Each comparison packs {count, if_empty_n, if_full_n, almost_full} into a 6-bit state word.
module tb_srl_hs_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic       if_write_ce;
  logic       if_write;
  logic [7:0] if_din;
  logic       if_full_n;
  logic       if_read_ce;
  logic       if_read;
  logic [7:0] if_dout;
  logic       if_empty_n;
  logic       almost_full;
  logic [2:0] count;

  int n_cmp = 0;
  int n_err = 0;

  logic [5:0] st;
  assign st = {count, if_empty_n, if_full_n, almost_full};

  srl_hs_fifo #(
    .DATA_WIDTH(8),
    .DEPTH     (4),
    .ADDR_WIDTH(2),
    .AF_MARGIN (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .if_write_ce(if_write_ce),
    .if_write   (if_write),
    .if_din     (if_din),
    .if_full_n  (if_full_n),
    .if_read_ce (if_read_ce),
    .if_read    (if_read),
    .if_dout    (if_dout),
    .if_empty_n (if_empty_n),
    .almost_full(almost_full),
    .count      (count)
  );

  always #5 clk = ~clk;

  // Wait for the next rising edge, then sample 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 1'b0; if_write = 1'b0; if_read = 1'b0;
    if_write_ce = 1'b1; if_read_ce = 1'b1; if_din = 8'h00;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (st !== 6'b000_010) begin
      n_err++; $display("FAIL reset_state: got %b want %b", st, 6'b000_010);
    end
  endtask

  task automatic test_fill();
    logic [7:0] data [4];
    logic [5:0] exp  [4];
    data = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp  = '{6'b001_110, 6'b010_110, 6'b011_111, 6'b100_101};
    for (int k = 0; k < 4; k++) begin
      if_write = 1'b1; if_din = data[k];
      tick();
      n_cmp++;
      if (st !== exp[k]) begin
        n_err++; $display("FAIL fill_state[%0d]: got %b want %b", k, st, exp[k]);
      end
      n_cmp++;
      if (if_dout !== 8'h11) begin
        n_err++; $display("FAIL fill_head[%0d]: got %h want 11", k, if_dout);
      end
    end
    idle();
  endtask

  // At full, write+read performs only the read. 0x55 must never appear.
  task automatic test_full_wr_rd();
    logic [7:0] heads [3];
    logic [5:0] exp   [3];
    heads = '{8'h33, 8'h44, 8'h00};
    exp   = '{6'b010_110, 6'b001_110, 6'b000_010};
    if_write = 1'b1; if_read = 1'b1; if_din = 8'h55;
    tick();
    idle();
    n_cmp++;
    if (st !== 6'b011_111) begin
      n_err++; $display("FAIL full_wr_rd_state: got %b want %b", st, 6'b011_111);
    end
    n_cmp++;
    if (if_dout !== 8'h22) begin
      n_err++; $display("FAIL full_wr_rd_head: got %h want 22", if_dout);
    end
    for (int k = 0; k < 3; k++) begin
      if_read = 1'b1;
      tick();
      n_cmp++;
      if (st !== exp[k]) begin
        n_err++; $display("FAIL drain_state[%0d]: got %b want %b", k, st, exp[k]);
      end
      if (k < 2) begin
        n_cmp++;
        if (if_dout !== heads[k]) begin
          n_err++; $display("FAIL drain_head[%0d]: got %h want %h", k, if_dout, heads[k]);
        end
      end
    end
    idle();
  endtask

  // At empty, write+read performs only the write. There is no fall-through.
  task automatic test_empty_rd_wr();
    if_read = 1'b1; if_write = 1'b1; if_din = 8'hA5;
    tick();
    if_write = 1'b0;
    n_cmp++;
    if (st !== 6'b001_110) begin
      n_err++; $display("FAIL empty_wr_state: got %b want %b", st, 6'b001_110);
    end
    n_cmp++;
    if (if_dout !== 8'hA5) begin
      n_err++; $display("FAIL empty_wr_head: got %h want a5", if_dout);
    end
    tick();
    n_cmp++;
    if (st !== 6'b000_010) begin
      n_err++; $display("FAIL empty_rd_state: got %b want %b", st, 6'b000_010);
    end
    idle();
  endtask

  // At count=2, simultaneous write+read keeps the count constant and preserves order.
  task automatic test_back_to_back();
    if_write = 1'b1; if_din = 8'h01; tick();
    if_din = 8'h02; tick();
    for (int k = 0; k < 6; k++) begin
      n_cmp++;
      if (if_dout !== 8'(k + 1)) begin
        n_err++; $display("FAIL b2b_head[%0d]: got %h want %h", k, if_dout, 8'(k + 1));
      end
      if_write = 1'b1; if_read = 1'b1; if_din = 8'(k + 3);
      tick();
      n_cmp++;
      if (st !== 6'b010_110) begin
        n_err++; $display("FAIL b2b_state[%0d]: got %b want %b", k, st, 6'b010_110);
      end
    end
    idle();
    n_cmp++;
    if (if_dout !== 8'h07) begin
      n_err++; $display("FAIL b2b_tail_head: got %h want 07", if_dout);
    end
    if_read = 1'b1; tick();
    n_cmp++;
    if (if_dout !== 8'h08) begin
      n_err++; $display("FAIL b2b_last_head: got %h want 08", if_dout);
    end
    tick();
    idle();
  endtask

  // Flush with a concurrent write clears the FIFO. The next write must read back as the head.
  task automatic test_flush();
    if_write = 1'b1;
    if_din = 8'h10; tick();
    if_din = 8'h20; tick();
    if_din = 8'h30; tick();
    n_cmp++;
    if (st !== 6'b011_111) begin
      n_err++; $display("FAIL pre_flush_state: got %b want %b", st, 6'b011_111);
    end
    flush = 1'b1; if_din = 8'h99;
    tick();
    idle();
    n_cmp++;
    if (st !== 6'b000_010) begin
      n_err++; $display("FAIL flush_state: got %b want %b", st, 6'b000_010);
    end
    if_write = 1'b1; if_din = 8'h77; tick();
    idle();
    n_cmp++;
    if (st !== 6'b001_110 || if_dout !== 8'h77) begin
      n_err++; $display("FAIL post_flush: got %b/%h want %b/77", st, if_dout, 6'b001_110);
    end
    if_read = 1'b1; tick();
    idle();
  endtask

  // Deasserted clock-enables block both accepts.
  task automatic test_ce_gating();
    if_write = 1'b1; if_write_ce = 1'b0; if_din = 8'hEE;
    tick(); tick();
    n_cmp++;
    if (st !== 6'b000_010) begin
      n_err++; $display("FAIL write_ce_gate: got %b want %b", st, 6'b000_010);
    end
    idle();
    if_write = 1'b1; if_din = 8'h3C; tick();
    idle();
    if_read = 1'b1; if_read_ce = 1'b0;
    tick();
    n_cmp++;
    if (st !== 6'b001_110 || if_dout !== 8'h3C) begin
      n_err++; $display("FAIL read_ce_gate: got %b/%h want %b/3c", st, if_dout, 6'b001_110);
    end
    idle();
  endtask

  // Reset asserted between clock edges must clear the flags before the next edge.
  task automatic test_async_reset();
    if_write = 1'b1; if_din = 8'hAA; tick();
    if_din = 8'hBB; tick();
    n_cmp++;
    if (st !== 6'b011_111) begin
      n_err++; $display("FAIL pre_reset_state: got %b want %b", st, 6'b011_111);
    end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (st !== 6'b000_010) begin
      n_err++; $display("FAIL async_reset_state: got %b want %b", st, 6'b000_010);
    end
    idle();
    #1;
    reset = 1'b0;
    tick();
    n_cmp++;
    if (st !== 6'b000_010) begin
      n_err++; $display("FAIL post_reset_idle: got %b want %b", st, 6'b000_010);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    #2;
    test_reset();
    test_fill();
    test_full_wr_rd();
    test_empty_rd_wr();
    test_back_to_back();
    test_flush();
    test_ce_gating();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
